// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt picker with multi-cycle flush and stall arbitration; `EXC_CNT_EN adds exc_cnt_o
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [4:0]  exc_flags_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_addr_o,
  output logic        exc_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [5:0]  stall_o,
`ifdef EXC_CNT_EN
  output logic [15:0] exc_cnt_o,
`endif
  output logic        busy_o
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [31:0] pc_q, pc_nx;
  logic int_pend, cand, exc;
  logic unused_bits;
  assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2], cp0_cause_i[31:16], cp0_cause_i[7:0]};
  assign int_pend = cp0_status_i[0] & ~cp0_status_i[1] & |(cp0_cause_i[15:8] & cp0_status_i[15:8]);
  assign cand = rst & inst_valid_i & (state == IDLE);
  // Pick one exception by priority; flags are {eret, ovf, trap, ri, syscall}
  always_comb begin
    excepttype_o = !cand          ? 32'h0 :
                   int_pend       ? 32'h1 :
                   exc_flags_i[1] ? 32'ha :
                   exc_flags_i[3] ? 32'hc :
                   exc_flags_i[2] ? 32'hd :
                   exc_flags_i[0] ? 32'h8 :
                   exc_flags_i[4] ? 32'he : 32'h0;
    exc = |excepttype_o;
    pc_nx = (excepttype_o == 32'he) ? cp0_epc_i : EXC_VECTOR;
    flush_o = rst & ((state == FLUSH) | exc);
    new_pc_o = !flush_o ? 32'h0 : (state == FLUSH) ? pc_q : pc_nx;
    stall_o = (!rst || flush_o || state != IDLE) ? 6'b000000 :
              stallreq_ex_i ? 6'b001111 :
              stallreq_id_i ? 6'b000111 : 6'b000000;
    busy_o = rst & (state == FLUSH);
    exc_addr_o = rst ? inst_addr_i : 32'h0;
    exc_delayslot_o = rst & in_delayslot_i;
  end
  // Flush sequencing: FLUSH holds the redirect for the remaining cnt cycles
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == FLUSH) begin
      cnt_nx = cnt - 4'd1;
      state_nx = (cnt == 4'd1) ? IDLE : FLUSH;
    end else if (exc && FLUSH_CYCLES > 1) begin
      state_nx = FLUSH;
      cnt_nx = 4'(FLUSH_CYCLES - 1);
    end
  end
  // State, counter and held redirect PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      pc_q <= 32'h0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (exc) pc_q <= pc_nx;
    end
  end
`ifdef EXC_CNT_EN
  // Saturating count of accepted non-eret exceptions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exc_cnt_o <= 16'h0;
    else if (exc && excepttype_o != 32'he && exc_cnt_o != 16'hffff) exc_cnt_o <= exc_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: vector table, corner sequences and randomized model check for exc_ctrl
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam int FC = 2;
  logic clk = 0, rst = 0, inst_valid_i = 0, in_delayslot_i = 0, stallreq_id_i = 0, stallreq_ex_i = 0;
  logic [4:0] exc_flags_i = '0;
  logic [31:0] inst_addr_i = '0, cp0_status_i = '0, cp0_cause_i = '0, cp0_epc_i = '0;
  logic [31:0] excepttype_o, exc_addr_o, new_pc_o;
  logic exc_delayslot_o, flush_o, busy_o;
  logic [5:0] stall_o;
`ifdef EXC_CNT_EN
  logic [15:0] exc_cnt_o;
`endif
  int passed = 0, total = 0;
  int rem = 0, mcnt = 0;
  logic [31:0] held = '0;
  typedef struct {
    logic v; logic [4:0] f; logic [31:0] st, ca, epc; logic sid, sex;
    logic [31:0] code; logic fl; logic [31:0] npc; logic [5:0] stall; logic busy;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .exc_flags_i(exc_flags_i),
    .inst_addr_i(inst_addr_i), .in_delayslot_i(in_delayslot_i), .cp0_status_i(cp0_status_i),
    .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .excepttype_o(excepttype_o), .exc_addr_o(exc_addr_o),
    .exc_delayslot_o(exc_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_o(stall_o),
`ifdef EXC_CNT_EN
    .exc_cnt_o(exc_cnt_o),
`endif
    .busy_o(busy_o));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [31:0] ref_code(input logic v, input logic [4:0] f, input logic [31:0] st, input logic [31:0] ca);
    logic ip;
    ip = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h0);
    if (!v) return 32'h0;
    if (ip) return 32'h1;
    if (f[1]) return 32'ha;
    if (f[3]) return 32'hc;
    if (f[2]) return 32'hd;
    if (f[0]) return 32'h8;
    if (f[4]) return 32'he;
    return 32'h0;
  endfunction
  task automatic clr_inputs();
    inst_valid_i = 0; exc_flags_i = '0; inst_addr_i = '0; in_delayslot_i = 0;
    cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0; stallreq_id_i = 0; stallreq_ex_i = 0;
  endtask
  task automatic do_reset();
    rst = 0; clr_inputs(); rem = 0; held = '0; mcnt = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask
  task automatic model_step();
    logic [31:0] code, npc;
    logic fl;
    logic [5:0] stl;
    code = (rem > 0) ? 32'h0 : ref_code(inst_valid_i, exc_flags_i, cp0_status_i, cp0_cause_i);
    fl = (rem > 0) || (code != 0);
    npc = (rem > 0) ? held : (code == 32'he) ? cp0_epc_i : VEC;
    stl = fl ? 6'b0 : stallreq_ex_i ? 6'b001111 : stallreq_id_i ? 6'b000111 : 6'b0;
    @(negedge clk);
    chk("rnd_code", excepttype_o, code);
    chk("rnd_flush", {31'b0, flush_o}, {31'b0, fl});
    chk("rnd_stall", {26'b0, stall_o}, {26'b0, stl});
    chk("rnd_busy", {31'b0, busy_o}, {31'b0, rem > 0});
    chk("rnd_addr", exc_addr_o, inst_addr_i);
    chk("rnd_ds", {31'b0, exc_delayslot_o}, {31'b0, in_delayslot_i});
    if (fl) chk("rnd_newpc", new_pc_o, npc);
`ifdef EXC_CNT_EN
    chk("rnd_cnt", {16'b0, exc_cnt_o}, 32'(mcnt));
`endif
    @(posedge clk); #1;
    if (rem > 0) rem--;
    else if (code != 0) begin rem = FC - 1; held = npc; end
    if (code != 0 && code != 32'he && mcnt < 65535) mcnt++;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 5'b00000, 32'h401, 32'h400, 32'h0, 1'b0, 1'b0, 32'h1, 1'b1, 32'h20, 6'h00, 1'b0};
    tbl[1]  = '{1'b1, 5'b00001, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h20, 6'h00, 1'b1};
    tbl[2]  = '{1'b1, 5'b00000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 6'h0f, 1'b0};
    tbl[3]  = '{1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 6'h07, 1'b0};
    tbl[4]  = '{1'b1, 5'b00010, 32'h403, 32'h400, 32'h0, 1'b0, 1'b0, 32'ha, 1'b1, 32'h20, 6'h00, 1'b0};
    tbl[5]  = '{1'b1, 5'b00000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 6'h00, 1'b1};
    tbl[6]  = '{1'b1, 5'b10000, 32'h0, 32'h0, 32'h1234, 1'b0, 1'b0, 32'he, 1'b1, 32'h1234, 6'h00, 1'b0};
    tbl[7]  = '{1'b1, 5'b00000, 32'h0, 32'h0, 32'h5555, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234, 6'h00, 1'b1};
    tbl[8]  = '{1'b0, 5'b01000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h00, 1'b0};
    tbl[9]  = '{1'b1, 5'b00001, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h20, 6'h00, 1'b0};
    tbl[10] = '{1'b1, 5'b00001, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 6'h00, 1'b1};
    tbl[11] = '{1'b1, 5'b01100, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hc, 1'b1, 32'h20, 6'h00, 1'b0};
    tbl[12] = '{1'b1, 5'b00000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 6'h00, 1'b1};
    tbl[13] = '{1'b1, 5'b00101, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hd, 1'b1, 32'h20, 6'h00, 1'b0};
    tbl[14] = '{1'b1, 5'b00000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 6'h00, 1'b1};
    tbl[15] = '{1'b1, 5'b11111, 32'h400, 32'h400, 32'h0, 1'b0, 1'b0, 32'ha, 1'b1, 32'h20, 6'h00, 1'b0};
    clr_inputs();
    inst_valid_i = 1; exc_flags_i = 5'b00001; inst_addr_i = 32'hdead_beef; in_delayslot_i = 1; stallreq_ex_i = 1;
    #3;
    chk("rst_code", excepttype_o, 32'h0);
    chk("rst_flush", {31'b0, flush_o}, 32'h0);
    chk("rst_stall", {26'b0, stall_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_addr", exc_addr_o, 32'h0);
    chk("rst_ds", {31'b0, exc_delayslot_o}, 32'h0);
    chk("rst_newpc", new_pc_o, 32'h0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      inst_valid_i = tbl[i].v; exc_flags_i = tbl[i].f; cp0_status_i = tbl[i].st; cp0_cause_i = tbl[i].ca;
      cp0_epc_i = tbl[i].epc; stallreq_id_i = tbl[i].sid; stallreq_ex_i = tbl[i].sex;
      inst_addr_i = 32'h1000 + 32'(i * 4); in_delayslot_i = i[0];
      @(negedge clk);
      chk($sformatf("vec%0d_code", i), excepttype_o, tbl[i].code);
      chk($sformatf("vec%0d_flush", i), {31'b0, flush_o}, {31'b0, tbl[i].fl});
      chk($sformatf("vec%0d_stall", i), {26'b0, stall_o}, {26'b0, tbl[i].stall});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy_o}, {31'b0, tbl[i].busy});
      chk($sformatf("vec%0d_addr", i), exc_addr_o, 32'h1000 + 32'(i * 4));
      chk($sformatf("vec%0d_ds", i), {31'b0, exc_delayslot_o}, {31'b0, i[0]});
      if (tbl[i].fl) chk($sformatf("vec%0d_newpc", i), new_pc_o, tbl[i].npc);
      @(posedge clk); #1;
    end
    do_reset();
    inst_valid_i = 1; exc_flags_i = 5'b00001;
    @(negedge clk);
    chk("mid_T_flush", {31'b0, flush_o}, 32'h1);
    @(posedge clk); #1;
    clr_inputs();
    #1;
    chk("mid_T1_busy", {31'b0, busy_o}, 32'h1);
    rst = 0;
    #1;
    chk("mid_rst_flush", {31'b0, flush_o}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    stallreq_ex_i = 1;
    @(negedge clk);
    chk("post_rst_flush", {31'b0, flush_o}, 32'h0);
    chk("post_rst_stall", {26'b0, stall_o}, 32'h0f);
    @(posedge clk); #1;
`ifdef EXC_CNT_EN
    do_reset();
    for (int i = 0; i < 4; i++) begin
      inst_valid_i = 1; exc_flags_i = (i == 3) ? 5'b10000 : 5'b00001;
      @(posedge clk); #1;
      clr_inputs();
      @(posedge clk); #1;
    end
    chk("cnt_three", {16'b0, exc_cnt_o}, 32'd3);
`endif
    do_reset();
    for (int n = 0; n < 400; n++) begin
      inst_valid_i = ($urandom_range(0, 3) != 0);
      exc_flags_i = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
      cp0_status_i = $urandom & 32'h0000_ff03;
      cp0_cause_i = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_ff00) : 32'h0;
      cp0_epc_i = $urandom;
      inst_addr_i = $urandom;
      in_delayslot_i = 1'($urandom);
      stallreq_id_i = 1'($urandom);
      stallreq_ex_i = ($urandom_range(0, 3) == 0);
      model_step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Pipeline exception and interrupt controller for the MIPS core.
- Sits beside the MEM stage. Each cycle it looks at the committing instruction's raw exception flags and the bypassed CP0 Status/Cause/EPC values, then picks at most one exception.
- For the chosen exception it drives the encoded exception type to the CP0 register block, asserts a multi-cycle pipeline flush, supplies the redirect PC, and otherwise arbitrates stage stall requests.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for all non-eret exceptions.
- FLUSH_CYCLES, 2, total cycles flush_o stays high per exception; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- inst_valid_i  in  1  MEM stage holds a real instruction (not a bubble)
- exc_flags_i  in  5  raw flags {eret, ovf, trap, ri, syscall}
- inst_addr_i  in  32  PC of the MEM-stage instruction
- in_delayslot_i  in  1  MEM instruction is in a delay slot
- cp0_status_i  in  32  bypassed Status
- cp0_cause_i  in  32  bypassed Cause
- cp0_epc_i  in  32  bypassed EPC
- stallreq_id_i  in  1  ID stage stall request
- stallreq_ex_i  in  1  EX stage stall request
- excepttype_o  out  32  code to CP0: 0 none, 1 int, 8 syscall, a ri, c ovf, d trap, e eret
- exc_addr_o  out  32  inst_addr_i passthrough to CP0
- exc_delayslot_o  out  1  in_delayslot_i passthrough to CP0
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect target, meaningful only while flush_o is high
- stall_o  out  6  {wb, mem, ex, id, if, pc} stall vector
- busy_o  out  1  FSM not in IDLE

Behaviour:
- int_pend = IE(status[0]) & ~EXL(status[1]) & |(cause[15:8] & status[15:8]).
- Exception candidate exists only when inst_valid_i=1 and the FSM is in IDLE. Otherwise excepttype_o = 0.
- Priority, highest first: int_pend, ri, ovf, trap, syscall, eret. Exactly one code is emitted.
- excepttype_o is combinational in the detect cycle T, so CP0 captures it at the end of T.
- exc_addr_o and exc_delayslot_o are pure passthroughs.
- new_pc_o in cycle T: cp0_epc_i for eret, EXC_VECTOR for everything else. It is registered and held through the whole flush.
- FSM states: IDLE and FLUSH, with a 4-bit counter cnt.
  - IDLE, excepttype_o != 0: flush_o=1 combinationally in T. Capture new_pc. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - FLUSH: flush_o=1, new_pc_o = held value, cnt decrements each cycle. When cnt==1, return to IDLE next cycle.
  - FLUSH: all new flags and interrupts are ignored, excepttype_o=0.
- Stall arbitration, only in IDLE with no exception:
  - stallreq_ex_i → stall_o=6'b001111.
  - else stallreq_id_i → 6'b000111.
  - else 6'b000000.
- Whenever flush_o=1, stall_o=0; flush always wins over stall.
- busy_o = (state==FLUSH).
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, held new_pc=0. All outputs are 0 while reset is asserted, including the combinational ones.
- Reset asserted mid-FLUSH aborts the flush immediately.
- Exception flags arriving while inst_valid_i=0 are ignored; a bubble never traps.
- Back-to-back exceptions: the second is taken only after the FSM is back in IDLE. The flushed instruction never re-presents its flags.

Optional Feature:
- Macro EXC_CNT_EN.
- When defined: adds output exc_cnt_o [15:0], a saturating count of accepted non-eret exceptions.
  - Increments at the end of each detect cycle T with code != 0 and != e.
  - Holds at 16'hFFFF once reached.
  - Resets to 0 on rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Interrupt: status=32'h0000_0401, cause[10]=1, inst_valid_i=1 → excepttype_o=1 in T; flush_o high T and T+1; new_pc_o=32'h20; stall_o=0.
- Masked interrupt and simultaneous ri: status EXL=1, cause[10]=1, flags={0,0,0,1,0} → excepttype_o=32'ha; interrupt not taken.
- eret: flags[4]=1, cp0_epc_i=32'h0000_1234 → excepttype_o=32'he; new_pc_o=32'h1234 held for FLUSH_CYCLES cycles.
- Stall vs flush: stallreq_ex_i=1 with syscall → stall_o=0 and flush_o=1 in T. Then stallreq_ex_i=1 with no exception, after returning to IDLE → stall_o=6'b001111.
- Flush window: second syscall in cycle T+1 → excepttype_o=0 at T+1. Bubble (inst_valid_i=0) with ovf flag → no flush.
- Reset: drop rst in cycle T+1 of a flush → flush_o=0 and busy_o=0 immediately. With EXC_CNT_EN, 3 syscalls then eret → exc_cnt_o=3.
